xoodyak_sequencer: RTL and testbench
====================================

Name: xoodyak_sequencer

Overview:
Command sequencer sitting directly upstream of xoodyak_build. Accepts one complete AEAD request (key, nonce, associated data, text, direction) over a valid/ready handshake. Drives the core's opmode/start sequence INIT -> NONCE -> ASSOC -> CRYPT/DECRYPT -> SQUEEZE, one step per core `finished` pulse. Returns text, tag and tag-check result over a valid/ready response handshake, with a per-step watchdog.

Parameters:
TIMEOUT_CLKS, 64, max eph1 cycles to wait for core_finished per step before aborting
TAG_W, 128, tag width taken from core_textout[TAG_W-1:0] during SQUEEZE

Ports:
eph1  in  1  clock
reset  in  1  asynchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_decrypt  in  1  1 = decrypt + verify, 0 = encrypt
req_key  in  128  key
req_nonce  in  128  nonce
req_ad  in  352  associated data
req_text  in  192  plaintext or ciphertext
req_tag  in  128  expected tag (decrypt only)
core_start  out  1  one-cycle start pulse to xoodyak_build
core_opmode  out  4  opmode to core: bit3 = continue, bits[2:0] = op
core_key / core_nonce / core_assodata / core_textin  out  128/128/352/192  registered request fields
core_textout  in  192  core data output
core_finished  in  1  core step-complete pulse
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_text  out  192  ciphertext/plaintext
rsp_tag  out  128  computed tag
rsp_tag_ok  out  1  decrypt: rsp_tag == stored req_tag; encrypt: 1
rsp_timeout  out  1  response is an abort caused by the watchdog
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, step 0, all outputs 0 except req_ready = 1; core_opmode = 4'h0 (idle).
- Op table, indexed by step 0..4: 1 init, 2 nonce, 3 assoc, 4 crypt (5 if decrypt), 6 squeeze. core_opmode = {step != 0, op}.
- IDLE: req_ready = 1. On req_valid & req_ready, register all req_* fields, step <= 0, go ISSUE. No other state asserts req_ready.
- ISSUE: one cycle; core_start = 1; core_opmode valid; clear watchdog; go WAIT.
- WAIT: core_opmode held; watchdog increments every cycle.
  - core_finished: step 3 -> capture core_textout into rsp_text; step 4 -> capture core_textout[TAG_W-1:0] into rsp_tag. If step == 4, go RESP; else step++, go ISSUE.
  - Watchdog reaches TIMEOUT_CLKS-1 without finished: rsp_timeout = 1, rsp_tag_ok = 0, go RESP.
  - finished in the same cycle the watchdog expires: finished wins.
  - core_finished in IDLE, ISSUE or RESP: ignored.
- RESP: rsp_valid = 1. rsp_* stable until rsp_ready. rsp_tag_ok is computed combinationally from registered values. On rsp_ready: go IDLE, rsp_timeout cleared.
- Latency: request accept -> first core_start = 1 cycle. Each step costs 1 cycle plus core latency. Last finished -> rsp_valid = 1 cycle.
- Back-to-back: earliest next req_ready is the cycle after the rsp handshake.
- Reset mid-operation: immediate abort to IDLE. No response emitted. core_start deasserts asynchronously.

Decomposition:
- Shared package xoodyak_pkg: opmode enum (IDLE=0, INIT=1, NONCE=2, ASSOC=3, CRYPT=4, DECRYPT=5, SQUEEZE=6, RATCHET=7), CONTINUE_BIT=3, field widths (KEY_W, NONCE_W, AD_W=352, TEXT_W=192), sequencer state enum.
- One sub-module: xoodyak_watchdog (counter with clear/enable/expire).

Test Plan:
- Encrypt, key 38393a…37, nonce 494a…48, text 4d4e…4c, core model finishes 10 cycles after start -> opmodes 1,A,B,C,E in order (A/B/C/E = continue bit set). Five start pulses. rsp_text/rsp_tag equal model output, rsp_tag_ok = 1.
- Decrypt with correct req_tag -> opmode step 3 = 4'hD, rsp_tag_ok = 1. Repeat with req_tag bit 0 flipped -> rsp_tag_ok = 0.
- Core never asserts finished on step 2 -> rsp_valid at cycle TIMEOUT_CLKS after that start, rsp_timeout = 1, rsp_tag_ok = 0. Next request proceeds normally.
- rsp_ready held low 20 cycles -> rsp_* stable, req_ready = 0 throughout. Spurious core_finished in RESP has no effect.
- Reset driven low during step 3 WAIT -> outputs return to reset values asynchronously. After release, req_ready = 1 and no rsp_valid.
- Finished arriving on the exact expiry cycle -> step advances, rsp_timeout = 0.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// Shared opmodes, field widths, request layout and sequencer states for the
// Xoodyak command path.
package xoodyak_pkg;

    localparam int KEY_W        = 128;
    localparam int NONCE_W      = 128;
    localparam int AD_W         = 352;
    localparam int TEXT_W       = 192;
    localparam int CONTINUE_BIT = 3;

    localparam logic [2:0] CRYPT_STEP = 3'd3;
    localparam logic [2:0] LAST_STEP  = 3'd4;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_INIT    = 3'd1,
        OP_NONCE   = 3'd2,
        OP_ASSOC   = 3'd3,
        OP_CRYPT   = 3'd4,
        OP_DECRYPT = 3'd5,
        OP_SQUEEZE = 3'd6,
        OP_RATCHET = 3'd7
    } opmode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic               decrypt;
        logic [KEY_W-1:0]   key;
        logic [NONCE_W-1:0] nonce;
        logic [AD_W-1:0]    ad;
        logic [TEXT_W-1:0]  text;
    } aead_req_t;

    function automatic opmode_e step_op(input logic [2:0] step, input logic decrypt);
        case (step)
            3'd0:    return OP_INIT;
            3'd1:    return OP_NONCE;
            3'd2:    return OP_ASSOC;
            3'd3:    return decrypt ? OP_DECRYPT : OP_CRYPT;
            3'd4:    return OP_SQUEEZE;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/xoodyak_watchdog.sv
// Per-step timeout counter: cleared when a step is issued, counts while the
// sequencer waits for the core.
module xoodyak_watchdog #(
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic eph1,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CLKS) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt = cnt_q + CW'(1);
    // Fires as the count steps onto TIMEOUT_CLKS-1, so the abort response
    // lands exactly TIMEOUT_CLKS cycles after the step's start pulse.
    assign expire  = en && (cnt_nxt == CW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en && !expire)
            cnt_q <= cnt_nxt;
    end

endmodule

// File: rtl/xoodyak_sequencer.sv
// Walks xoodyak_build through INIT/NONCE/ASSOC/CRYPT/SQUEEZE for one AEAD
// request and returns text, tag and tag check, aborting a stuck step.
module xoodyak_sequencer
    import xoodyak_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 64,
    parameter int TAG_W        = 128
) (
    input  logic               eph1,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_decrypt,
    input  logic [KEY_W-1:0]   req_key,
    input  logic [NONCE_W-1:0] req_nonce,
    input  logic [AD_W-1:0]    req_ad,
    input  logic [TEXT_W-1:0]  req_text,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               core_start,
    output logic [3:0]         core_opmode,
    output logic [KEY_W-1:0]   core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [AD_W-1:0]    core_assodata,
    output logic [TEXT_W-1:0]  core_textin,
    input  logic [TEXT_W-1:0]  core_textout,
    input  logic               core_finished,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TEXT_W-1:0]  rsp_text,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_tag_ok,
    output logic               rsp_timeout,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    aead_req_t          req_q;
    logic [TAG_W-1:0]   exp_tag_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TEXT_W-1:0]  text_q;
    logic [2:0]         step_q;
    logic               timeout_q;

    logic accept, fin_hit, abort, wd_clr, wd_en, wd_expire;

    xoodyak_watchdog #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_wd (
        .eph1   (eph1),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fin_hit = 1'b0;
        abort   = 1'b0;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // A finish on the expiry cycle still counts as a completed step.
                if (core_finished) begin
                    fin_hit = 1'b1;
                    state_d = (step_q == LAST_STEP) ? ST_RESP : ST_ISSUE;
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            exp_tag_q <= '0;
            step_q    <= '0;
            text_q    <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q     <= '{decrypt: req_decrypt, key: req_key, nonce: req_nonce,
                               ad: req_ad, text: req_text};
                exp_tag_q <= req_tag;
                step_q    <= '0;
                text_q    <= '0;
                tag_q     <= '0;
            end
            if (fin_hit) begin
                if (step_q == CRYPT_STEP)
                    text_q <= core_textout;
                if (step_q == LAST_STEP)
                    tag_q <= core_textout[TAG_W-1:0];
                else
                    step_q <= step_q + 3'd1;
            end
            if (abort)
                timeout_q <= 1'b1;
            else if (state_q == ST_RESP && rsp_ready)
                timeout_q <= 1'b0;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign core_start    = (state_q == ST_ISSUE);
    assign core_opmode   = (state_q == ST_ISSUE || state_q == ST_WAIT)
                         ? {step_q != 3'd0, step_op(step_q, req_q.decrypt)} : 4'h0;
    assign core_key      = req_q.key;
    assign core_nonce    = req_q.nonce;
    assign core_assodata = req_q.ad;
    assign core_textin   = req_q.text;

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_text    = text_q;
    assign rsp_tag     = tag_q;
    assign rsp_timeout = timeout_q;
    assign rsp_tag_ok  = (state_q == ST_RESP) && !timeout_q
                       && (!req_q.decrypt || (tag_q == exp_tag_q));

endmodule

// File: tb/tb_xoodyak_sequencer.sv
// Scoreboard bench for xoodyak_sequencer with a latency-programmable core model.
module tb_xoodyak_sequencer;
    import xoodyak_pkg::*;

    localparam int T = 16;

    logic               eph1 = 1'b0;
    logic               reset = 1'b0;
    logic               req_valid = 1'b0, req_ready, req_decrypt = 1'b0;
    logic [KEY_W-1:0]   req_key = '0;
    logic [NONCE_W-1:0] req_nonce = '0;
    logic [AD_W-1:0]    req_ad = '0;
    logic [TEXT_W-1:0]  req_text = '0;
    logic [127:0]       req_tag = '0;
    logic               core_start;
    logic [3:0]         core_opmode;
    logic [KEY_W-1:0]   core_key;
    logic [NONCE_W-1:0] core_nonce;
    logic [AD_W-1:0]    core_assodata;
    logic [TEXT_W-1:0]  core_textin;
    logic [TEXT_W-1:0]  core_textout = '0;
    logic               core_finished;
    logic               rsp_valid, rsp_ready = 1'b0;
    logic [TEXT_W-1:0]  rsp_text;
    logic [127:0]       rsp_tag;
    logic               rsp_tag_ok, rsp_timeout, busy;

    xoodyak_sequencer #(.TIMEOUT_CLKS(T), .TAG_W(128)) dut (
        .eph1(eph1), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
        .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad),
        .req_text(req_text), .req_tag(req_tag),
        .core_start(core_start), .core_opmode(core_opmode), .core_key(core_key),
        .core_nonce(core_nonce), .core_assodata(core_assodata), .core_textin(core_textin),
        .core_textout(core_textout), .core_finished(core_finished),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
        .rsp_tag(rsp_tag), .rsp_tag_ok(rsp_tag_ok), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 eph1 = ~eph1;

    typedef struct {
        logic [TEXT_W-1:0] text;
        logic [127:0]      tag;
        logic              tag_ok;
        logic              timeout;
        int                nstart;
        logic [19:0]       ops;
        int                delta;
    } exp_t;

    exp_t q_exp[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_start_cyc = 0, starts_seen = 0;
    int lat = 10, hang_step = -1;
    logic [19:0] obs_ops = '0;
    logic model_fin = 1'b0, spur_fin = 1'b0, pend = 1'b0;
    int mcnt = 0;
    logic [3:0] mop = '0;

    assign core_finished = model_fin | spur_fin;

    function automatic logic [TEXT_W-1:0] model_out(input logic [3:0] op, input logic [127:0] key,
                                                    input logic [127:0] nonce, input logic [TEXT_W-1:0] text);
        case (op[2:0])
            3'd4, 3'd5: return text ^ {key[63:0], key};
            3'd6:       return {64'hFFFF_0000_FFFF_0000, key ^ nonce ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0};
            default:    return {48{op}};
        endcase
    endfunction

    always @(posedge eph1) cyc++;

    // Core model plus start monitor, evaluated mid-cycle.
    always @(negedge eph1 or negedge reset) begin
        model_fin = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else if (core_start) begin
            if (starts_seen < 5) obs_ops[starts_seen*4 +: 4] = core_opmode;
            pend = (starts_seen != hang_step);
            mcnt = lat;
            mop = core_opmode;
            last_start_cyc = cyc;
            starts_seen++;
        end else if (pend) begin
            mcnt--;
            if (mcnt == 0) begin
                model_fin = 1'b1;
                pend = 1'b0;
                core_textout = model_out(mop, core_key, core_nonce, core_textin);
            end
        end
    end

    task automatic send_req(input string name, input logic dec, input logic [127:0] key, nonce,
                            input logic [AD_W-1:0] ad, input logic [TEXT_W-1:0] text, input logic [127:0] tag);
        exp_t e;
        logic [TEXT_W-1:0] sq;
        logic [19:0] mask;
        int tstep;
        sq = model_out(4'h6, key, nonce, text);
        tstep = (lat >= T) ? 0 : hang_step;
        e.ops = dec ? 20'hEDBA1 : 20'hECBA1;
        if (tstep >= 0) begin
            mask = '0;
            for (int i = 0; i <= tstep; i++) mask[i*4 +: 4] = 4'hF;
            e.ops = e.ops & mask;
            e.text = '0; e.tag = '0; e.tag_ok = 1'b0; e.timeout = 1'b1;
            e.nstart = tstep + 1; e.delta = T;
        end else begin
            e.text = model_out(dec ? 4'hD : 4'hC, key, nonce, text);
            e.tag = sq[127:0];
            e.tag_ok = dec ? (sq[127:0] == tag) : 1'b1;
            e.timeout = 1'b0; e.nstart = 5; e.delta = lat + 1;
        end
        @(negedge eph1);
        starts_seen = 0; obs_ops = '0;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b want 1", name, req_ready); end
        req_valid = 1'b1; req_decrypt = dec; req_key = key; req_nonce = nonce;
        req_ad = ad; req_text = text; req_tag = tag;
        @(posedge eph1); #1;
        req_valid = 1'b0;
        q_exp.push_back(e);
        n_chk++; if (core_start !== 1'b1 || core_opmode !== 4'h1) begin n_fail++;
            $display("FAIL %s first start: got start=%b op=%h want 1/1", name, core_start, core_opmode); end
        n_chk++; if (core_key !== key || core_nonce !== nonce || core_assodata !== ad || core_textin !== text) begin
            n_fail++; $display("FAIL %s core fields: got key=%h textin=%h want %h %h", name, core_key, core_textin, key, text); end
        n_chk++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++;
            $display("FAIL %s busy/req_ready: got %b/%b want 1/0", name, busy, req_ready); end
    endtask

    task automatic wait_rsp(input string name, input int hold);
        exp_t e;
        int b;
        b = 0;
        while (rsp_valid !== 1'b1 && b < 400) begin @(negedge eph1); b++; end
        n_chk++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s rsp_valid: got %b want 1 within budget", name, rsp_valid); return; end
        e = q_exp.pop_front();
        n_chk++; if (cyc - last_start_cyc != e.delta) begin n_fail++;
            $display("FAIL %s rsp latency: got %0d want %0d", name, cyc - last_start_cyc, e.delta); end
        n_chk++; if (starts_seen != e.nstart || obs_ops !== e.ops) begin n_fail++;
            $display("FAIL %s opmodes: got n=%0d ops=%h want n=%0d ops=%h", name, starts_seen, obs_ops, e.nstart, e.ops); end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin spur_fin = (i == 5); @(negedge eph1); spur_fin = 1'b0; end
            n_chk++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++;
                $display("FAIL %s hold%0d valid/ready: got %b/%b want 1/0", name, i, rsp_valid, req_ready); end
            n_chk++; if (rsp_timeout !== e.timeout || rsp_tag_ok !== e.tag_ok) begin n_fail++;
                $display("FAIL %s hold%0d timeout/tag_ok: got %b/%b want %b/%b", name, i, rsp_timeout, rsp_tag_ok, e.timeout, e.tag_ok); end
            if (!e.timeout) begin
                n_chk++; if (rsp_text !== e.text || rsp_tag !== e.tag) begin n_fail++;
                    $display("FAIL %s hold%0d text/tag: got %h %h want %h %h", name, i, rsp_text, rsp_tag, e.text, e.tag); end
            end
        end
        rsp_ready = 1'b1;
        @(posedge eph1); #1;
        rsp_ready = 1'b0;
        n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_timeout !== 1'b0) begin n_fail++;
            $display("FAIL %s after handshake: got valid=%b ready=%b timeout=%b want 0/1/0", name, rsp_valid, req_ready, rsp_timeout); end
    endtask

    logic [127:0] k0 = 128'h38393a3b3c3d3e3f3031323334353637;
    logic [127:0] n0 = 128'h494a4b4c4d4e4f404142434445464748;
    logic [191:0] t0 = 192'h4d4e4f50_51525354_55565758_595a5b5c_45464748_494a4b4c;
    logic [351:0] a0 = {11{32'h41424344}};

    task automatic test_reset();
        #12;
        n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || core_opmode !== 4'h0) begin n_fail++;
            $display("FAIL reset ctrl: got ready=%b busy=%b start=%b op=%h want 1/0/0/0", req_ready, busy, core_start, core_opmode); end
        n_chk++; if (rsp_valid !== 1'b0 || rsp_tag_ok !== 1'b0 || rsp_timeout !== 1'b0 || rsp_text !== '0 || core_key !== '0) begin n_fail++;
            $display("FAIL reset rsp: got valid=%b ok=%b to=%b text=%h key=%h want zeros", rsp_valid, rsp_tag_ok, rsp_timeout, rsp_text, core_key); end
        @(negedge eph1); reset = 1'b1;
        @(negedge eph1);
        n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL reset release: got ready=%b busy=%b want 1/0", req_ready, busy); end
    endtask

    task automatic test_encrypt();
        send_req("enc", 1'b0, k0, n0, a0, t0, '0);
        wait_rsp("enc", 0);
    endtask

    task automatic test_decrypt();
        logic [191:0] sq;
        sq = model_out(4'h6, k0, n0, t0);
        send_req("dec_good", 1'b1, k0, n0, a0, t0, sq[127:0]);
        wait_rsp("dec_good", 0);
        send_req("dec_bad", 1'b1, k0, n0, a0, t0, sq[127:0] ^ 128'h1);
        wait_rsp("dec_bad", 0);
    endtask

    task automatic test_timeout();
        hang_step = 2;
        send_req("hang2", 1'b0, k0 ^ 128'h77, n0, a0, t0, '0);
        wait_rsp("hang2", 0);
        hang_step = -1;
        send_req("after_hang", 1'b0, k0, n0 ^ 128'hF0, a0, t0 ^ 192'h3, '0);
        wait_rsp("after_hang", 0);
    endtask

    task automatic test_back_to_back();
        send_req("bp", 1'b0, ~k0, n0, a0, ~t0, '0);
        wait_rsp("bp", 20);
        send_req("b2b", 1'b1, k0, ~n0, a0, t0, 128'hDEAD);
        wait_rsp("b2b", 0);
    endtask

    task automatic test_expiry_edge();
        lat = T - 1;
        send_req("edge_fin", 1'b0, k0, n0, a0, t0 ^ 192'h55, '0);
        wait_rsp("edge_fin", 0);
        lat = T;
        send_req("edge_late", 1'b0, k0, n0, a0, t0, '0);
        wait_rsp("edge_late", 0);
        lat = 10;
    endtask

    task automatic test_reset_mid_op();
        int b;
        send_req("rst_mid", 1'b0, k0, n0, a0, t0, '0);
        b = 0;
        while (starts_seen < 4 && b < 200) begin @(negedge eph1); b++; end
        repeat (3) @(negedge eph1);
        n_chk++; if (busy !== 1'b1 || core_opmode !== 4'hC) begin n_fail++;
            $display("FAIL rst_mid pre: got busy=%b op=%h want 1/c", busy, core_opmode); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0 || core_opmode !== 4'h0 || core_key !== '0) begin n_fail++;
            $display("FAIL rst_mid async: got ready=%b busy=%b op=%h key=%h want 1/0/0/0", req_ready, busy, core_opmode, core_key); end
        q_exp.delete();
        @(negedge eph1); reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge eph1);
            n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
                $display("FAIL rst_mid after%0d: got valid=%b ready=%b want 0/1", i, rsp_valid, req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_timeout();
        test_back_to_back();
        test_expiry_edge();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
